// File: rtl/ps_pc_stack.sv
// ---------------------------------------------------------------------------
// ps_pc_stack : hardware PC / ureg stack for the program sequencer.
//
// Each cycle the push/pop requests are classified into one of five
// operations (IDLE, PUSH, POP, REPLACE, ERR). A pop result is registered and
// accompanied by a one-cycle valid strobe. Overflow/underflow attempts leave
// the stack untouched and set sticky flags that only ps_stk_clr or reset
// clear. If a new error coincides with the clear, the flag stays set.
//
// Ports
//   clk             : single clock, rising edge active
//   reset           : synchronous active-low reset
//   ps_pshstck      : push request (one entry per cycle)
//   ps_popstck      : pop request (one entry per cycle)
//   ps_stk_din      : push data
//   ps_stk_clr      : clears the sticky overflow/underflow flags
//   ps_stk_dout     : registered popped value, held between pops
//   ps_stk_dout_vld : one-cycle strobe for a valid pop result
//   ps_stk_top      : combinational top entry, 0 when empty
//   ps_stk_lvl      : occupancy, 0..DEPTH
//   ps_stk_empty    : lvl == 0
//   ps_stk_full     : lvl == DEPTH
//   ps_stk_ovf      : sticky, push attempted while full
//   ps_stk_udf      : sticky, pop attempted while empty
// ---------------------------------------------------------------------------
module ps_pc_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps_pshstck,
  input  logic             ps_popstck,
  input  logic [WIDTH-1:0] ps_stk_din,
  input  logic             ps_stk_clr,
  output logic [WIDTH-1:0] ps_stk_dout,
  output logic             ps_stk_dout_vld,
  output logic [WIDTH-1:0] ps_stk_top,
  output logic [5:0]       ps_stk_lvl,
  output logic             ps_stk_empty,
  output logic             ps_stk_full,
  output logic             ps_stk_ovf,
  output logic             ps_stk_udf
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] LVL_MAX = 6'(DEPTH);

  typedef enum logic [2:0] {
    OP_IDLE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_ERR     = 3'd4
  } op_e;

  // Storage and state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [5:0]       r_lvl;
  logic [WIDTH-1:0] r_dout;
  logic             r_vld;
  logic             r_ovf;
  logic             r_udf;

  // Combinational control
  op_e              w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_set_ovf;
  logic             w_set_udf;
  logic             w_wr_en;
  logic             w_pop_vld;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic [5:0]       w_lvl_nxt;
  logic [WIDTH-1:0] w_top;

  assign w_empty   = (r_lvl == 6'd0);
  assign w_full    = (r_lvl == LVL_MAX);
  // Only meaningful when not empty; the wrap at lvl=0 is masked by w_empty.
  assign w_top_idx = AW'(r_lvl - 6'd1);

  // Top-of-stack view; zero when empty so stale entries never leak out.
  always_comb begin
    w_top = {WIDTH{1'b0}};
    if (w_empty) begin
      w_top = {WIDTH{1'b0}};
    end else begin
      w_top = r_mem[w_top_idx];
    end
  end

  // Classify the request pair into one operation and detect error events.
  always_comb begin
    w_op      = OP_IDLE;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    case ({ps_pshstck, ps_popstck})
      2'b11: begin
        // Replace on an empty stack degenerates into a push plus underflow.
        if (w_empty) begin
          w_op      = OP_PUSH;
          w_set_udf = 1'b1;
        end else begin
          w_op      = OP_REPLACE;
        end
      end
      2'b10: begin
        if (w_full) begin
          w_op      = OP_ERR;
          w_set_ovf = 1'b1;
        end else begin
          w_op      = OP_PUSH;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_op      = OP_ERR;
          w_set_udf = 1'b1;
        end else begin
          w_op      = OP_POP;
        end
      end
      default: begin
        w_op = OP_IDLE;
      end
    endcase
  end

  // Per-operation datapath controls: write enable/index, next level, pop strobe.
  always_comb begin
    w_lvl_nxt = r_lvl;
    w_wr_en   = 1'b0;
    w_wr_idx  = AW'(r_lvl);
    w_pop_vld = 1'b0;
    case (w_op)
      OP_PUSH: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = AW'(r_lvl);
        w_lvl_nxt = r_lvl + 6'd1;
      end
      OP_POP: begin
        w_lvl_nxt = r_lvl - 6'd1;
        w_pop_vld = 1'b1;
      end
      OP_REPLACE: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = w_top_idx;
        w_pop_vld = 1'b1;
      end
      default: begin
        w_lvl_nxt = r_lvl;
      end
    endcase
  end

  // Level, popped data, valid strobe and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lvl  <= 6'd0;
      r_dout <= {WIDTH{1'b0}};
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_lvl <= w_lvl_nxt;
      r_vld <= w_pop_vld;
      if (w_pop_vld) begin
        r_dout <= w_top;
      end else begin
        r_dout <= r_dout;
      end
      // Set dominates clear.
      r_ovf <= w_set_ovf | (r_ovf & ~ps_stk_clr);
      r_udf <= w_set_udf | (r_udf & ~ps_stk_clr);
    end
  end

  // Entry storage; not reset, hidden behind lvl after reset.
  always_ff @(posedge clk) begin
    if (reset && w_wr_en) begin
      r_mem[w_wr_idx] <= ps_stk_din;
    end
  end

  assign ps_stk_dout     = r_dout;
  assign ps_stk_dout_vld = r_vld;
  assign ps_stk_top      = w_top;
  assign ps_stk_lvl      = r_lvl;
  assign ps_stk_empty    = w_empty;
  assign ps_stk_full     = w_full;
  assign ps_stk_ovf      = r_ovf;
  assign ps_stk_udf      = r_udf;

endmodule

// File: doc/ps_pc_stack.md
PS_PC_STACK -- requirements
Module: ps_pc_stack

Interface
REQ-001 Parameter DEPTH, default 16, number of stack entries; legal range 2 to 32.
REQ-002 Parameter WIDTH, default 16, data width of each entry.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 ps_pshstck  input  1  push request, one entry per asserted cycle.
REQ-006 ps_popstck  input  1  pop request, one entry per asserted cycle.
REQ-007 ps_stk_din  input  WIDTH  push data (return PC or ureg value from the data bus).
REQ-008 ps_stk_clr  input  1  clears the sticky overflow and underflow flags.
REQ-009 ps_stk_dout  output  WIDTH  registered popped value, driven onto the bus when the DI select is 01.
REQ-010 ps_stk_dout_vld  output  1  one-cycle strobe marking a valid pop result on ps_stk_dout.
REQ-011 ps_stk_top  output  WIDTH  combinational current top entry; 0 when empty.
REQ-012 ps_stk_lvl  output  6  current occupancy, 0 to DEPTH.
REQ-013 ps_stk_empty  output  1  high when ps_stk_lvl is 0.
REQ-014 ps_stk_full  output  1  high when ps_stk_lvl equals DEPTH.
REQ-015 ps_stk_ovf  output  1  sticky flag: a push was attempted while full.
REQ-016 ps_stk_udf  output  1  sticky flag: a pop was attempted while empty.

Function
REQ-017 The controller SHALL act in exactly one of five cases each cycle: IDLE, PUSH, POP, REPLACE (push and pop together), or ERR.
REQ-018 PUSH (push only, not full): the entry at index lvl SHALL take ps_stk_din and lvl SHALL increment by 1 at the next edge.
REQ-019 POP (pop only, not empty): ps_stk_dout SHALL take the entry at index lvl-1 and lvl SHALL decrement by 1.
REQ-020 POP: ps_stk_dout_vld SHALL be high for exactly the following cycle (1-cycle latency).
REQ-021 REPLACE with lvl>0: ps_stk_dout SHALL take the old top, the top entry SHALL take ps_stk_din, lvl SHALL be unchanged, and ps_stk_dout_vld SHALL pulse.
REQ-022 REPLACE with lvl=0: the block SHALL behave as PUSH and SHALL set ps_stk_udf.
REQ-023 Push while full and not popping: storage and lvl SHALL be unchanged and ps_stk_ovf SHALL be set.
REQ-024 Pop while empty and not pushing: ps_stk_dout SHALL hold its value, ps_stk_dout_vld SHALL stay low, and ps_stk_udf SHALL be set.
REQ-025 ps_stk_ovf and ps_stk_udf SHALL remain set until ps_stk_clr or reset.
REQ-026 If ps_stk_clr coincides with a new error, the flag SHALL end up set (set wins over clear).
REQ-027 ps_stk_dout SHALL hold its last value between pops.
REQ-028 lvl SHALL never exceed DEPTH and SHALL never wrap below 0.
REQ-029 ps_stk_empty and ps_stk_full SHALL be derived from registered lvl with no extra cycle of delay.

Reset
REQ-030 While reset is low at a clock edge, the block SHALL clear lvl, ps_stk_dout, ps_stk_dout_vld, ps_stk_ovf and ps_stk_udf to 0, which also forces ps_stk_empty to 1 and ps_stk_full to 0.
REQ-031 Reset SHALL take priority over any push, pop or clear in the same cycle.
REQ-032 Entry storage need not be reset, but no entry contents SHALL be visible on any output after reset.

Verification
REQ-033 Bench SHALL cover: reset, then push 0x1234, 0x5678, then pop twice -> dout 0x5678 then 0x1234, vld pulse each cycle after the pop, lvl 2 -> 1 -> 0, empty=1.
REQ-034 Bench SHALL cover: push 16 values with DEPTH=16, then push 0xBEEF -> full=1, ovf=1, lvl=16, the next pop returns the 16th value (not 0xBEEF).
REQ-035 Bench SHALL cover: pop while empty -> udf=1, vld=0, dout unchanged; clr the next cycle -> udf=0.
REQ-036 Bench SHALL cover: lvl=1 with top 0x00AA, then push and pop together with din 0x00BB -> dout=0x00AA, vld=1, lvl=1, top=0x00BB.
REQ-037 Bench SHALL cover: push 3 values, assert reset for one cycle together with a push -> lvl=0, empty=1, ovf=0, udf=0, dout=0.
REQ-038 Bench SHALL cover: ovf set with clr and a new overflowing push in the same cycle -> ovf remains 1.
